multi_temp_sensor_poller: RTL

Parametrised, multi-channel successor to the single-sensor temperature reader. Polls up to NUM_CH sensors round-robin, pulses a read request to the selected sensor, waits for its valid-tagged reply with a timeout, and pushes a channel-tagged sample into the downstream FIFO with full-flag back-pressure. Sits between the sensor bus mux and the sample FIFO.

---
 rtl/multi_temp_sensor_poller.sv | 100 ++++++++++
 1 files changed

// File: rtl/multi_temp_sensor_poller.sv
// Round-robin poller for up to NUM_CH temperature sensors: requests a reading,
// waits for a valid-tagged reply with timeout, and writes {channel, sample} downstream.
module multi_temp_sensor_poller #(
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 15,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fifo_full,
  input  logic [NUM_CH-1:0]      ch_en,
  input  logic [DATA_W:0]        din_sensor,
  output logic                   dout_sensor,
  output logic [CH_W-1:0]        sensor_sel,
  output logic [CH_W+DATA_W-1:0] data_to_fifo,
  output logic                   fifo_wr,
  output logic                   timeout_err
);

  // Handshakes: the sensor reply counts only while waiting, when din_sensor[DATA_W]
  // is high; a write is issued only when fifo_full was low at the deciding edge.
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, PUSH, ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state;
  logic [7:0]      wait_cnt;
  logic [CH_W-1:0] next_ch;
  logic [CH_W-1:0] idx;

  // Nearest enabled channel after the current one; scanning from the far end
  // lets the closest candidate overwrite the others.
  always_comb begin
    next_ch = sensor_sel;
    idx     = sensor_sel;
    for (int i = NUM_CH - 1; i >= 1; i--) begin
      idx = CH_W'((32'(sensor_sel) + i) % NUM_CH);
      if (ch_en[idx]) next_ch = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sensor_sel   <= '0;
      dout_sensor  <= 1'b0;
      fifo_wr      <= 1'b0;
      timeout_err  <= 1'b0;
      data_to_fifo <= '0;
      wait_cnt     <= '0;
    end else begin
      dout_sensor <= 1'b0;
      fifo_wr     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!ch_en[sensor_sel]) begin
            sensor_sel <= next_ch;
          end else if (!fifo_full) begin
            state       <= REQ;
            dout_sensor <= 1'b1;
          end
        end
        REQ: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A reply arriving on the final counted cycle still wins over the timeout.
          if (din_sensor[DATA_W]) begin
            data_to_fifo <= {sensor_sel, din_sensor[DATA_W-1:0]};
            state        <= HOLD;
          end else if (wait_cnt == CNT_LAST) begin
            state       <= ERR;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (!fifo_full) begin
            state   <= PUSH;
            fifo_wr <= 1'b1;
          end
        end
        PUSH: begin
          sensor_sel <= next_ch;
          state      <= IDLE;
        end
        ERR: begin
          sensor_sel <= next_ch;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
